// File: rtl/cnn_window_gen.sv
// cnn_window_gen: raster-scans a padded IMG_W x IMG_H image and emits every 3x3 window in raster order.
// Latency: window valid 2 cycles after its bottom-right pixel's read is issued; done_o 1 cycle after the last window.
// Backpressure: hold_i stalls read issue only; reads already in flight are always consumed. Option macro WIN_COORD_EN adds win_row_o/win_col_o.
module cnn_window_gen #(
   parameter int IMG_W  = 66,
   parameter int IMG_H  = 66,
   parameter int ADDR_W = 13
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              image_ready,
   input  logic              hold_i,
   output logic              image_rden_o,
   output logic [ADDR_W-1:0] image_addr_o,
   input  logic [7:0]        image_i,
   input  logic              image_valid,
   output logic              win_valid_o,
   output logic [71:0]       win_data_o,
`ifdef WIN_COORD_EN
   output logic [5:0]        win_row_o,
   output logic [5:0]        win_col_o,
`endif
   output logic              done_o
);

   localparam int NPIX = IMG_W * IMG_H;
   localparam int NWIN = (IMG_W - 2) * (IMG_H - 2);
   localparam int CW   = $clog2(IMG_W);
   localparam int RW   = $clog2(IMG_H);
   localparam int NW   = $clog2(NWIN + 1);
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NPIX - 1);

   typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

   state_t            state_q;
   logic [ADDR_W-1:0] addr_q;
   logic [NW-1:0]     wcnt_q;
   logic              done_q;
   logic              pend_q;
   logic [CW-1:0]     col_q;
   logic [RW-1:0]     row_q;
   logic              win_valid_q;
   logic [71:0]       win_data_q;
   logic [7:0]        win_q   [3][3];
   logic [7:0]        win_nxt [3][3];
   logic [71:0]       win_pack;
   logic [7:0]        lb0_q [IMG_W];   // row-1
   logic [7:0]        lb1_q [IMG_W];   // row-2
   logic              issue, accept, emit;
`ifdef WIN_COORD_EN
   logic [5:0]        win_row_q, win_col_q;
`endif

   // A read goes out every FETCH cycle unless stalled; the address is the registered counter.
   assign issue        = (state_q == FETCH) && !hold_i;
   assign image_rden_o = issue;
   assign image_addr_o = addr_q;
   // Only data answering one of our own reads is accepted.
   assign accept       = image_valid && pend_q;
   assign emit         = accept && (row_q >= RW'(2)) && (col_q >= CW'(2));

   assign win_valid_o  = win_valid_q;
   assign win_data_o   = win_data_q;
   assign done_o       = done_q;
`ifdef WIN_COORD_EN
   assign win_row_o    = win_row_q;
   assign win_col_o    = win_col_q;
`endif

   // Next window: shift columns left and append the column ending in the incoming pixel.
   always_comb begin
      for (int r = 0; r < 3; r++) begin
         win_nxt[r][0] = win_q[r][1];
         win_nxt[r][1] = win_q[r][2];
      end
      win_nxt[0][2] = lb1_q[col_q];
      win_nxt[1][2] = lb0_q[col_q];
      win_nxt[2][2] = image_i;
      win_pack = '0;
      for (int r = 0; r < 3; r++) begin
         for (int c = 0; c < 3; c++) begin
            win_pack[8*(3*r+c) +: 8] = win_nxt[r][c];
         end
      end
   end

   // Frame sequencing: read address counter, window count and the done pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         addr_q  <= '0;
         wcnt_q  <= '0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (win_valid_q && state_q != IDLE) wcnt_q <= wcnt_q + NW'(1);
         case (state_q)
            IDLE: begin
               if (image_ready) begin
                  state_q <= FETCH;
                  addr_q  <= '0;
                  wcnt_q  <= '0;
               end
            end
            FETCH: begin
               if (issue) begin
                  if (addr_q == LAST_ADDR) state_q <= DRAIN;
                  else                     addr_q  <= addr_q + ADDR_W'(1);
               end
            end
            DRAIN: begin
               if (win_valid_q && wcnt_q == NW'(NWIN - 1)) begin
                  state_q <= DONE;
                  done_q  <= 1'b1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // Pixel position tracking, 3x3 window shift register and registered window outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend_q      <= 1'b0;
         col_q       <= '0;
         row_q       <= '0;
         win_valid_q <= 1'b0;
         win_data_q  <= '0;
         for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
               win_q[r][c] <= '0;
`ifdef WIN_COORD_EN
         win_row_q   <= '0;
         win_col_q   <= '0;
`endif
      end else begin
         pend_q      <= issue;
         win_valid_q <= emit;
         if (state_q == IDLE && image_ready) begin
            col_q <= '0;
            row_q <= '0;
         end else if (accept) begin
            if (col_q == CW'(IMG_W - 1)) begin
               col_q <= '0;
               row_q <= (row_q == RW'(IMG_H - 1)) ? '0 : row_q + RW'(1);
            end else begin
               col_q <= col_q + CW'(1);
            end
         end
         if (accept) win_q <= win_nxt;
         if (emit) begin
            win_data_q <= win_pack;
`ifdef WIN_COORD_EN
            win_row_q  <= 6'(row_q - RW'(2));
            win_col_q  <= 6'(col_q - CW'(2));
`endif
         end
      end
   end

   // Line buffers: the column slot moves row-1 into row-2 and takes the new pixel as row-1.
   always_ff @(posedge clk) begin
      if (accept) begin
         lb1_q[col_q] <= lb0_q[col_q];
         lb0_q[col_q] <= image_i;
      end
   end

endmodule

// File: tb/tb_cnn_window_gen.sv
// Directed bench for cnn_window_gen: ramp image memory, frame runs with hold, ignored start, mid-frame reset.
// Memory model answers every read one cycle later with data = address[7:0].
// Window contents are checked against a closed-form expectation of the ramp image.
module tb_cnn_window_gen;

   localparam int W      = 66;
   localparam int H      = 66;
   localparam int NWIN   = (W - 2) * (H - 2);
   localparam int NREADS = W * H;
   localparam int BASE_DUR = NREADS + 3;   // ready cycle -> done cycle

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        image_ready = 1'b0;
   logic        hold_i = 1'b0;
   logic        image_rden_o;
   logic [12:0] image_addr_o;
   logic [7:0]  image_i = 8'h00;
   logic        image_valid = 1'b0;
   logic        win_valid_o;
   logic [71:0] win_data_o;
   logic        done_o;
`ifdef WIN_COORD_EN
   logic [5:0]  win_row_o, win_col_o;
`endif

   always #5 clk = ~clk;

   cnn_window_gen #(.IMG_W(W), .IMG_H(H), .ADDR_W(13)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .image_ready  (image_ready),
      .hold_i       (hold_i),
      .image_rden_o (image_rden_o),
      .image_addr_o (image_addr_o),
      .image_i      (image_i),
      .image_valid  (image_valid),
      .win_valid_o  (win_valid_o),
      .win_data_o   (win_data_o),
`ifdef WIN_COORD_EN
      .win_row_o    (win_row_o),
      .win_col_o    (win_col_o),
`endif
      .done_o       (done_o)
   );

   int checks = 0;
   int errors = 0;

   int cyc = 0;
   int s_cyc, t134, first_cyc, last_win_cyc, done_cyc;
   int nwin, nreads, done_cnt, addr_bad, win_bad, hold_bad, coord_bad, exp_addr;
   logic [71:0] first_data, last_data;
   logic        pend_n = 1'b0;
   logic [12:0] a_n = '0;
   logic        spur = 1'b0;

   task automatic check_val(input string tag, input logic [71:0] obs, input logic [71:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [71:0] exp_win(input int n);
      logic [71:0] v;
      int r0, c0, a;
      r0 = n / (W - 2);
      c0 = n % (W - 2);
      v = '0;
      for (int k = 0; k < 9; k++) begin
         a = (r0 + k / 3) * W + c0 + k % 3;
         v[8*k +: 8] = a[7:0];
      end
      return v;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_stats();
      nwin = 0; nreads = 0; done_cnt = 0; addr_bad = 0; win_bad = 0;
      hold_bad = 0; coord_bad = 0; exp_addr = 0;
      t134 = -100; first_cyc = -1; last_win_cyc = -1; done_cyc = -1;
      first_data = '0; last_data = '0;
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Image memory: latch the request at negedge, present data in the following cycle.
   always @(negedge clk) begin
      pend_n = image_rden_o;
      a_n    = image_addr_o;
   end
   always begin
      @(posedge clk);
      #2;
      image_valid = pend_n | spur;
      image_i     = spur ? 8'hEE : a_n[7:0];
   end

   // Output monitor.
   always @(negedge clk) begin
      if (rst_n) begin
         if (image_rden_o) begin
            if (image_addr_o !== 13'(exp_addr)) addr_bad++;
            if (image_addr_o == 13'd134) t134 = cyc;
            if (hold_i) hold_bad++;
            exp_addr++;
            nreads++;
         end
         if (win_valid_o) begin
            if (nwin == 0) begin
               first_data = win_data_o;
               first_cyc  = cyc;
            end
            if (win_data_o !== exp_win(nwin)) win_bad++;
`ifdef WIN_COORD_EN
            if (win_row_o !== 6'(nwin / (W - 2)) || win_col_o !== 6'(nwin % (W - 2))) coord_bad++;
`endif
            last_data    = win_data_o;
            last_win_cyc = cyc;
            nwin++;
         end
         if (done_o) begin
            done_cnt++;
            done_cyc = cyc;
         end
      end
   end

   task automatic run_frame(input string tag, input int hold_start, input int ready2_at);
      int dur;
      clear_stats();
      image_ready = 1'b1;
      s_cyc = cyc;
      step();
      image_ready = 1'b0;
      for (int k = 1; k < 6000 && done_cnt == 0; k++) begin
         hold_i      = (hold_start > 0 && k >= hold_start && k < hold_start + 10);
         image_ready = (k == ready2_at);
         step();
      end
      hold_i = 1'b0;
      image_ready = 1'b0;
      repeat (4) step();
      dur = BASE_DUR + ((hold_start > 0) ? 10 : 0);
      check_val({tag, "_done_cnt"},   72'(done_cnt), 72'd1);
      check_val({tag, "_nwin"},       72'(nwin), 72'(NWIN));
      check_val({tag, "_nreads"},     72'(nreads), 72'(NREADS));
      check_val({tag, "_addr_seq"},   72'(addr_bad), 72'd0);
      check_val({tag, "_win_seq"},    72'(win_bad), 72'd0);
      check_val({tag, "_hold_rden"},  72'(hold_bad), 72'd0);
      check_val({tag, "_first_win"},  first_data, 72'h86_85_84_44_43_42_02_01_00);
      check_val({tag, "_first_lat"},  72'(first_cyc - t134), 72'd2);
      check_val({tag, "_last_win"},   last_data, 72'h03_02_01_C1_C0_BF_7F_7E_7D);
      check_val({tag, "_done_after"}, 72'(done_cyc - last_win_cyc), 72'd1);
      check_val({tag, "_duration"},   72'(done_cyc - s_cyc), 72'(dur));
      check_val({tag, "_data_hold"},  win_data_o, 72'h03_02_01_C1_C0_BF_7F_7E_7D);
`ifdef WIN_COORD_EN
      check_val({tag, "_coords"},     72'(coord_bad), 72'd0);
`endif
   endtask

   initial begin
      clear_stats();
      #1 rst_n = 1'b0;
      #1;
      check_val("rst_rden",  72'(image_rden_o), 72'd0);
      check_val("rst_addr",  72'(image_addr_o), 72'd0);
      check_val("rst_valid", 72'(win_valid_o), 72'd0);
      check_val("rst_data",  win_data_o, 72'd0);
      check_val("rst_done",  72'(done_o), 72'd0);
`ifdef WIN_COORD_EN
      check_val("rst_coord", 72'({win_row_o, win_col_o}), 72'd0);
`endif
      repeat (3) step();
      rst_n = 1'b1;
      repeat (2) step();

      // Unsolicited image_valid in IDLE must not disturb the next frame.
      spur = 1'b1;
      repeat (3) step();
      spur = 1'b0;
      repeat (3) step();
      check_val("spur_novalid", 72'(nwin), 72'd0);

      run_frame("plain", 0, 0);
      run_frame("hold", 300, 0);
      run_frame("ready2", 0, 1000);

      // Reset while address 2000 is being presented.
      clear_stats();
      image_ready = 1'b1;
      step();
      image_ready = 1'b0;
      for (int k = 0; k < 3000; k++) begin
         if (image_rden_o && image_addr_o == 13'd2000) break;
         step();
      end
      check_val("abort_reached", 72'(image_addr_o), 72'd2000);
      rst_n = 1'b0;
      #1;
      check_val("abort_rden",  72'(image_rden_o), 72'd0);
      check_val("abort_addr",  72'(image_addr_o), 72'd0);
      check_val("abort_valid", 72'(win_valid_o), 72'd0);
      check_val("abort_data",  win_data_o, 72'd0);
      check_val("abort_done",  72'(done_o), 72'd0);
      repeat (3) step();
      rst_n = 1'b1;
      repeat (2) step();
      run_frame("after_rst", 0, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
